// File: rtl/ps2_rx_if.sv
// Receive-side result bundle of the PS/2 receiver: decoded byte, one-cycle good/bad strobes, frame-in-progress flag.
// No flow control: strobes are single-cycle and the consumer must take them as they come.
interface ps2_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic       busy;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_error,
      output busy
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input rx_error,
      input busy
   );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync + deglitch clock, deserialize 11-bit frames, check parity/stop, time out stalls.
// Raw clock fall to internal edge is 2 + FILTER_LEN + 1 cycles; strobes one cycle after the stop-bit edge; no backpressure.
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 7425
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     ps2_clk_in,
   input  logic     ps2_data_in,
   ps2_rx_if.master rx
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt, clk_filt_q;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   state_t        state, state_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          par, par_nxt;
   logic [TW-1:0] to_cnt, to_cnt_nxt;
   logic [7:0]    data_q, data_nxt;
   logic          valid_q, valid_nxt;
   logic          error_q, error_nxt;
   logic          good;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         clk_filt   <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_s1     <= ps2_clk_in;
         clk_s2     <= clk_s1;
         dat_s1     <= ps2_data_in;
         dat_s2     <= dat_s1;
         clk_filt_q <= clk_filt;
         // The level flips on the FILTER_LEN-th consecutive disagreeing sample
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = clk_filt_q & ~clk_filt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         to_cnt  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         par     <= par_nxt;
         to_cnt  <= to_cnt_nxt;
         data_q  <= data_nxt;
         valid_q <= valid_nxt;
         error_q <= error_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      par_nxt     = par;
      to_cnt_nxt  = to_cnt;
      data_nxt    = data_q;
      valid_nxt   = 1'b0;
      error_nxt   = 1'b0;
      good        = dat_s2 & (^{shreg, par});

      if (state == IDLE || fall) begin
         to_cnt_nxt = '0;
      end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
         to_cnt_nxt = to_cnt + 1'b1;
      end

      // An edge in the same cycle as the timeout keeps the frame alive
      if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
               end
            end
            DATA: begin
               shreg_nxt[bit_cnt] = dat_s2;
               bit_cnt_nxt        = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = dat_s2;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (good) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
               end else begin
                  error_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state != IDLE && to_cnt_nxt == TW'(TIMEOUT_CYCLES)) begin
         state_nxt = IDLE;
         error_nxt = 1'b1;
      end
   end

   assign rx.rx_data  = data_q;
   assign rx.rx_valid = valid_q;
   assign rx.rx_error = error_q;
   assign rx.busy     = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frame table plus hand sequences for glitches, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_rx;
   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 7425;

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   ps2_rx_if rx_if ();

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk),
      .ps2_data_in (ps2_dat),
      .rx          (rx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0, error_cnt = 0, both_cnt = 0, busy_cyc = 0;
   int cyc = 0, err_cyc = 0, last_fall_cyc = 0;

   always @(posedge clk) begin
      #2;
      cyc++;
      if (rx_if.rx_valid) valid_cnt++;
      if (rx_if.rx_error) begin
         error_cnt++;
         err_cyc = cyc;
      end
      if (rx_if.rx_valid && rx_if.rx_error) both_cnt++;
      if (rx_if.busy) busy_cyc++;
   end

   typedef struct {
      logic [7:0] d;
      logic       bad_par;
      logic       stop;
      int         exp_v;
      int         exp_e;
      logic [7:0] exp_d;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int half);
      @(negedge clk);
      ps2_dat = b;
      wait_cyc(half);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop, input int half);
      send_bit(1'b0, half);
      for (int i = 0; i < 8; i++) send_bit(d[i], half);
      send_bit((~^d) ^ bad_par, half);
      send_bit(stop, half);
      ps2_dat = 1'b1;
      wait_cyc(20);
   endtask

   initial begin
      int v0, e0, b0, delta;
      vecs[0] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0};
      vecs[1] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
      vecs[2] = '{8'hA5, 1'b1, 1'b1, 0, 1, 8'h1C};
      vecs[3] = '{8'h3C, 1'b0, 1'b0, 0, 1, 8'h1C};
      vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};
      vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 0, 1, 8'hFF};

      wait_cyc(3);
      check("rst_data",  int'(rx_if.rx_data),  0);
      check("rst_valid", int'(rx_if.rx_valid), 0);
      check("rst_error", int'(rx_if.rx_error), 0);
      check("rst_busy",  int'(rx_if.busy),     0);
      @(negedge clk) rst = 1'b1;
      wait_cyc(5);

      // 0x1C at 12.5 kHz (297-cycle half period)
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 297);
      check("slow_valid", valid_cnt - v0, 1);
      check("slow_error", error_cnt - e0, 0);
      check("slow_data",  int'(rx_if.rx_data), 'h1C);
      check("slow_busy",  int'(rx_if.busy), 0);

      for (int i = 0; i < 7; i++) begin
         v0 = valid_cnt; e0 = error_cnt;
         send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop, 40);
         check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_v);
         check($sformatf("vec%0d_error", i), error_cnt - e0, vecs[i].exp_e);
         check($sformatf("vec%0d_data", i),  int'(rx_if.rx_data), int'(vecs[i].exp_d));
         check($sformatf("vec%0d_busy", i),  int'(rx_if.busy), 0);
      end

      // Short glitch must be swallowed; a long one with data high is a false start
      b0 = busy_cyc; e0 = error_cnt;
      @(negedge clk);
      ps2_dat = 1'b0;
      ps2_clk = 1'b0;
      wait_cyc(4);
      ps2_clk = 1'b1;
      wait_cyc(30);
      check("glitch_busy",  busy_cyc - b0, 0);
      check("glitch_error", error_cnt - e0, 0);
      ps2_dat = 1'b1;
      ps2_clk = 1'b0;
      wait_cyc(FILTER_LEN + 2);
      ps2_clk = 1'b1;
      wait_cyc(30);
      check("false_start_busy",  busy_cyc - b0, 0);
      check("false_start_error", error_cnt - e0, 0);

      // Stalled frame: start + 3 data bits, then silence
      v0 = valid_cnt; e0 = error_cnt;
      send_bit(1'b0, 40);
      check("stall_busy_mid", int'(rx_if.busy), 1);
      send_bit(1'b0, 40);
      send_bit(1'b0, 40);
      send_bit(1'b1, 40);
      ps2_dat = 1'b1;
      for (int n = 0; n < TIMEOUT_CYCLES + 200 && error_cnt == e0; n++) @(negedge clk);
      delta = (error_cnt != e0) ? err_cyc - last_fall_cyc : -1;
      check_range("timeout_latency", delta, TIMEOUT_CYCLES + 10, TIMEOUT_CYCLES + 12);
      wait_cyc(5);
      check("timeout_error", error_cnt - e0, 1);
      check("timeout_valid", valid_cnt - v0, 0);
      check("timeout_busy",  int'(rx_if.busy), 0);
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 40);
      check("post_to_valid", valid_cnt - v0, 1);
      check("post_to_error", error_cnt - e0, 0);
      check("post_to_data",  int'(rx_if.rx_data), 'h1C);

      // Reset after the 5th data bit
      send_bit(1'b0, 40);
      send_bit(1'b0, 40);
      send_bit(1'b0, 40);
      send_bit(1'b1, 40);
      send_bit(1'b1, 40);
      send_bit(1'b1, 40);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_data",  int'(rx_if.rx_data),  0);
      check("midrst_valid", int'(rx_if.rx_valid), 0);
      check("midrst_error", int'(rx_if.rx_error), 0);
      check("midrst_busy",  int'(rx_if.busy),     0);
      wait_cyc(3);
      rst = 1'b1;
      wait_cyc(5);
      v0 = valid_cnt; e0 = error_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 40);
      check("post_rst_valid", valid_cnt - v0, 1);
      check("post_rst_error", error_cnt - e0, 0);
      check("post_rst_data",  int'(rx_if.rx_data), 'h1C);

      check("valid_error_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receives the PS/2 device-to-host serial stream and delivers validated scan-code bytes to `ps2_kb`, which decodes make/break sequences into the Chip-8 key state. Runs on the 7.425 MHz system clock, oversampling the keyboard clock and data lines. The top level handles the open-collector `inout` pins, and this block sees inputs only. The block synchronizes and deglitches the PS/2 clock, deserializes 11-bit frames, checks framing and parity, and recovers from stalled frames.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 7425: maximum `clk` cycles allowed between filtered falling edges inside a frame (1 ms at 7.425 MHz).
- `clk` input 1: system clock, 7.425 MHz.
- `rst` input 1: reset, asynchronous, active-low.
- `ps2_clk_in` input 1: raw PS/2 clock line; asynchronous, idles high.
- `ps2_data_in` input 1: raw PS/2 data line; asynchronous, idles high.
- `rx_data` output 8: last received byte; holds its value until the next good frame.
- `rx_valid` output 1: one-cycle pulse, `rx_data` is new and good.
- `rx_error` output 1: one-cycle pulse on parity, stop-bit or timeout failure.
- `busy` output 1: high while a frame is in progress (not IDLE).

## Operation
- Both raw inputs pass through 2-flop synchronizers.
- Clock filter:
  - A counter of width `$clog2(FILTER_LEN+1)` counts cycles where the synchronized clock differs from `clk_filt`.
  - The counter clears when the two agree.
  - When the count reaches `FILTER_LEN`, `clk_filt` takes the new level and the counter clears.
- Falling edge:
  - `fall` is high for one cycle when the registered `clk_filt` goes 1→0.
  - Synchronized data is sampled in that same cycle.
- Frame format, one bit per `fall`: start (0), D0..D7 LSB first, odd parity, stop (1).
- States:
  - IDLE: on `fall` with data=0, go to DATA and set bit count to 0. On `fall` with data=1 (false start), stay in IDLE with no error.
  - DATA: shift the sampled bit into bit `count` of the shift register. After the 8th bit, go to PARITY.
  - PARITY: store the sampled bit and go to STOP.
  - STOP: the frame is good if stop=1 and XOR of (D0..D7, parity) = 1. Good: load `rx_data` and pulse `rx_valid`. Bad: pulse `rx_error` and leave `rx_data` unchanged. Either way, return to IDLE.
- Timeout:
  - A cycle counter clears on every `fall` and counts in states other than IDLE, saturating at `TIMEOUT_CYCLES`.
  - When it reaches `TIMEOUT_CYCLES`, force IDLE and pulse `rx_error`.
  - If `fall` and timeout occur in the same cycle, the edge wins and the counter clears.
- `rx_valid` and `rx_error` are never high together.
- Reset, asynchronous and applicable mid-frame:
  - State goes to IDLE.
  - `rx_data`=0x00; `rx_valid`, `rx_error`, `busy` = 0.
  - `clk_filt`=1 and both synchronizers = 1.
  - All counters = 0; the partial frame is discarded.

## Timing
- Raw clock fall to `fall` pulse: 2 (sync) + `FILTER_LEN` + 1 cycles, i.e. 11 cycles at default.
- Data is sampled at `fall`. PS/2 holds data well beyond 11 cycles (~1.5 µs) after clock falls, so data needs no filtering.
- `rx_valid` and `rx_error` rise on the cycle after the stop-bit `fall`. `rx_data` updates on that same cycle.
- `busy` rises on the cycle after the start-bit `fall` and falls together with the `rx_valid` or `rx_error` pulse.
- Timeout `rx_error` fires exactly `TIMEOUT_CYCLES` cycles after the last `fall` in a frame.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk_in` produce no `fall`.
- Back-to-back frames need no gap beyond the PS/2 inter-frame idle time. A start-bit `fall` on the cycle after the stop pulse is accepted.

## Test plan
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz PS/2 clock → exactly one `rx_valid` pulse, `rx_data`=0x1C, `rx_error` stays 0, `busy` low afterward.
- Frame 0xF0 followed immediately by 0x1C → two `rx_valid` pulses, carrying 0xF0 (parity bit 1) then 0x1C.
- Frame 0x1C with parity bit 1 → one `rx_error` pulse, no `rx_valid`, `rx_data` keeps its previous value. Repeat with stop bit 0 → same response.
- 4-cycle low glitch on idle `ps2_clk_in` with data=0 → no `fall`, `busy` stays 0. Glitch of `FILTER_LEN`+2 cycles with data=1 → `fall` fires but the false start leaves `busy` at 0 and no error.
- Start bit plus 3 data bits, then the clock held high → `rx_error` exactly 7425 cycles after the last `fall`, `busy` 0. A following good 0x1C frame decodes correctly.
- `rst` asserted low after the 5th data bit of a frame → all outputs at their reset values immediately (asynchronously). After `rst` rises, a full 0x1C frame → `rx_valid` with 0x1C and no residue from the partial frame.
